// File: rtl/nn_layer_sequencer.sv
// Layer sequencer for the shared 784-30-15-10 fully-connected datapath.
// Walks one input element per clock through L1, L2 and L3, then pulses done.
module nn_layer_sequencer #(
  parameter int L1_IN  = 784,
  parameter int L1_OUT = 30,
  parameter int L2_OUT = 15,
  parameter int L3_OUT = 10,
  parameter int IDX_W  = 10,
  parameter int ADDR_W = 15
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              start,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic [1:0]        layer,
  output logic [IDX_W-1:0]  in_idx,
  output logic [ADDR_W-1:0] w_addr,
  output logic              bias_sel,
  output logic              acc_en,
  output logic              act_latch,
  output logic              relu_en
);

  typedef enum logic [2:0] {
    IDLE,
    L1,
    L2,
    L3,
    FIN
  } state_t;

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] last_idx;
  logic [31:0]      out_cnt;
  logic             last;

  // Per-layer input bound and weight-row stride.
  always_comb begin
    last_idx = '0;
    out_cnt  = '0;
    unique case (state)
      L1: begin
        last_idx = IDX_W'(L1_IN - 1);
        out_cnt  = 32'(L1_OUT);
      end
      L2: begin
        last_idx = IDX_W'(L1_OUT - 1);
        out_cnt  = 32'(L2_OUT);
      end
      L3: begin
        last_idx = IDX_W'(L2_OUT - 1);
        out_cnt  = 32'(L3_OUT);
      end
      default: ;
    endcase
  end

  assign last = (idx == last_idx);

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state <= IDLE;
      idx   <= '0;
    end else if (abort) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          idx <= '0;
          if (start) state <= L1;
        end
        L1: begin
          idx <= last ? '0 : idx + IDX_W'(1);
          if (last) state <= L2;
        end
        L2: begin
          idx <= last ? '0 : idx + IDX_W'(1);
          if (last) state <= L3;
        end
        L3: begin
          idx <= last ? '0 : idx + IDX_W'(1);
          if (last) state <= FIN;
        end
        FIN: begin
          idx   <= '0;
          state <= IDLE;
        end
        default: begin
          idx   <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

  // Outputs are pure decodes of state/idx, so reset clears them at once.
  always_comb begin
    layer = 2'd0;
    unique case (state)
      L1:      layer = 2'd1;
      L2:      layer = 2'd2;
      L3:      layer = 2'd3;
      default: layer = 2'd0;
    endcase
  end

  assign busy      = (state != IDLE);
  assign done      = (state == FIN);
  assign acc_en    = (layer != 2'd0);
  assign relu_en   = (state == L1) || (state == L2);
  assign in_idx    = idx;
  assign bias_sel  = acc_en && (idx == '0);
  assign act_latch = relu_en && last;
  assign w_addr    = ADDR_W'(32'(idx) * out_cnt);

endmodule

// File: tb/tb_nn_layer_sequencer.sv
// Directed bench for nn_layer_sequencer: default-size and small-size
// instances, vector table for the full run plus abort/reset/back-to-back.
module tb_nn_layer_sequencer;

  logic        Clk;
  logic        Rst_n;
  logic        start;
  logic        abort;
  logic        busy;
  logic        done;
  logic [1:0]  layer;
  logic [9:0]  in_idx;
  logic [14:0] w_addr;
  logic        bias_sel;
  logic        acc_en;
  logic        act_latch;
  logic        relu_en;

  logic        start_s;
  logic        abort_s;
  logic        busy_s;
  logic        done_s;
  logic [1:0]  layer_s;
  logic [9:0]  in_idx_s;
  logic [14:0] w_addr_s;
  logic        bias_sel_s;
  logic        acc_en_s;
  logic        act_latch_s;
  logic        relu_en_s;

  int nvec;
  int nfail;

  nn_layer_sequencer dut (
    .Clk(Clk), .Rst_n(Rst_n), .start(start), .abort(abort),
    .busy(busy), .done(done), .layer(layer), .in_idx(in_idx),
    .w_addr(w_addr), .bias_sel(bias_sel), .acc_en(acc_en),
    .act_latch(act_latch), .relu_en(relu_en)
  );

  nn_layer_sequencer #(
    .L1_IN(4), .L1_OUT(3), .L2_OUT(2), .L3_OUT(2)
  ) dut_s (
    .Clk(Clk), .Rst_n(Rst_n), .start(start_s), .abort(abort_s),
    .busy(busy_s), .done(done_s), .layer(layer_s), .in_idx(in_idx_s),
    .w_addr(w_addr_s), .bias_sel(bias_sel_s), .acc_en(acc_en_s),
    .act_latch(act_latch_s), .relu_en(relu_en_s)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    int          cyc;
    logic [32:0] exp;
  } vec_t;

  function automatic logic [32:0] mk(
    input logic b, input logic d, input logic [1:0] l,
    input int i, input int a,
    input logic bs, input logic ac, input logic at, input logic r);
    logic [9:0]  iv;
    logic [14:0] av;
    iv = i[9:0];
    av = a[14:0];
    return {b, d, l, iv, av, bs, ac, at, r};
  endfunction

  function automatic logic [32:0] obs();
    return {busy, done, layer, in_idx, w_addr,
            bias_sel, acc_en, act_latch, relu_en};
  endfunction

  task automatic chk(input string name, input logic [32:0] got,
                     input logic [32:0] want);
    nvec++;
    if (got !== want) begin
      nfail++;
      $display("FAIL %s got %h want %h", name, got, want);
    end
  endtask

  task automatic chki(input string name, input int got, input int want);
    nvec++;
    if (got != want) begin
      nfail++;
      $display("FAIL %s got %0d want %0d", name, got, want);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  vec_t tbl[10];
  int   sm_idx[10];
  int   sm_lay[10];

  initial begin
    int ti, nd, nb, na, dcyc;
    int d1, d2, d3, cyc;

    nvec    = 0;
    nfail   = 0;
    start   = 0;
    abort   = 0;
    start_s = 0;
    abort_s = 0;
    Rst_n   = 0;

    tbl[0] = '{1,   mk(1, 0, 1, 0,   0,     1, 1, 0, 1)};
    tbl[1] = '{2,   mk(1, 0, 1, 1,   30,    0, 1, 0, 1)};
    tbl[2] = '{784, mk(1, 0, 1, 783, 23490, 0, 1, 1, 1)};
    tbl[3] = '{785, mk(1, 0, 2, 0,   0,     1, 1, 0, 1)};
    tbl[4] = '{786, mk(1, 0, 2, 1,   15,    0, 1, 0, 1)};
    tbl[5] = '{814, mk(1, 0, 2, 29,  435,   0, 1, 1, 1)};
    tbl[6] = '{815, mk(1, 0, 3, 0,   0,     1, 1, 0, 0)};
    tbl[7] = '{829, mk(1, 0, 3, 14,  140,   0, 1, 0, 0)};
    tbl[8] = '{830, mk(1, 1, 0, 0,   0,     0, 0, 0, 0)};
    tbl[9] = '{831, mk(0, 0, 0, 0,   0,     0, 0, 0, 0)};

    sm_idx = '{0, 1, 2, 3, 0, 1, 2, 0, 1, 0};
    sm_lay = '{1, 1, 1, 1, 2, 2, 2, 3, 3, 0};

    #1;
    chk("reset_outputs", obs(), '0);
    #12;
    Rst_n = 1;
    step();
    step();
    chk("idle_after_reset", obs(), '0);

    // Full default run, table-driven.
    start = 1;
    step();
    start = 0;
    ti = 0; nd = 0; nb = 0; na = 0; dcyc = -1;
    for (int c = 1; c <= 831; c++) begin
      if (c > 1) step();
      if (done) begin nd++; dcyc = c; end
      if (bias_sel) nb++;
      if (act_latch) na++;
      if (ti < 10 && tbl[ti].cyc == c) begin
        chk($sformatf("full_c%0d", c), obs(), tbl[ti].exp);
        ti++;
      end
    end
    chki("done_count", nd, 1);
    chki("done_cycle", dcyc, 830);
    chki("bias_count", nb, 3);
    chki("act_count", na, 2);

    // Abort mid-L2.
    start = 1;
    step();
    start = 0;
    for (int c = 2; c <= 800; c++) step();
    chki("pre_abort_layer", int'(layer), 2);
    abort = 1;
    step();
    abort = 0;
    chk("abort_idle", obs(), '0);
    nd = 0;
    for (int c = 0; c < 900; c++) begin
      step();
      if (done) nd++;
    end
    chki("abort_no_done", nd, 0);
    start = 1;
    step();
    start = 0;
    dcyc = -1;
    for (int c = 2; c <= 900 && dcyc < 0; c++) begin
      step();
      if (done) dcyc = c;
    end
    chki("after_abort_done_cycle", dcyc, 830);
    step();

    // start held high: back-to-back runs.
    start = 1;
    d1 = -1; d2 = -1; d3 = -1;
    cyc = 0;
    for (int c = 1; c <= 2600; c++) begin
      step();
      cyc = c;
      if (done) begin
        if (d1 < 0) d1 = c;
        else if (d2 < 0) d2 = c;
        else if (d3 < 0) d3 = c;
      end
    end
    start = 0;
    chki("b2b_first_done", d1, 830);
    chki("b2b_gap1", d2 - d1, 831);
    chki("b2b_gap2", d3 - d2, 831);
    for (int c = 0; c < 900 && busy; c++) step();
    chki("b2b_drained", int'(busy), 0);

    // Async reset mid-L1.
    start = 1;
    step();
    start = 0;
    for (int c = 0; c < 100; c++) step();
    chki("pre_reset_layer", int'(layer), 1);
    #2;
    Rst_n = 0;
    #1;
    chk("async_reset", obs(), '0);
    @(negedge Clk);
    Rst_n = 1;
    for (int c = 0; c < 20; c++) step();
    chk("idle_after_release", obs(), '0);

    // Small-parameter instance.
    start_s = 1;
    step();
    start_s = 0;
    for (int c = 1; c <= 10; c++) begin
      if (c > 1) step();
      chki($sformatf("small_idx_c%0d", c), int'(in_idx_s), sm_idx[c-1]);
      chki($sformatf("small_layer_c%0d", c), int'(layer_s), sm_lay[c-1]);
      chki($sformatf("small_done_c%0d", c), int'(done_s), (c == 10) ? 1 : 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
